svm_packer: RTL
===============

Name: svm_packer

Overview:
- Upstream feeder of the SVM classifier's 128-bit input FIFO.
- Accepts a 32-bit beat stream of 8-bit feature bytes and packs four beats into each 128-bit FIFO word.
- Frames every sample to exactly SAMPLE_BYTES bytes: short records are zero-padded, over-long records are truncated. The classifier therefore always sees whole 512-word samples.

Parameters:
- SAMPLE_BYTES, 8192, bytes per sample. Must be a multiple of 16.
- WORDS = SAMPLE_BYTES/16, 512, derived (localparam): 128-bit words per sample.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_data  in  32  four feature bytes; in_data[7:0] is the earliest byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  qualifies the final beat of a record.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- wr_data  out  128  packed word to FIFO.
- wr_en  out  1  FIFO write strobe.
- wr_full  in  1  FIFO full.
- sample_count  out  16  completed samples, wraps at 65535->0.
- overflow  out  1  sticky: a record exceeded SAMPLE_BYTES.

Behaviour:
- Reset (async assert, sync release): state=FILL, beat index 0, word count 0, wr_data=0, sample_count=0, overflow=0, in_ready=1, wr_en=0.
- Byte order: the k-th accepted beat of a word (k=0..3) lands in wr_data[32k+31:32k]. The earliest byte of a sample is therefore wr_data[7:0] of word 0.
- States: FILL, PUSH, PAD, DROP.
- FILL:
  - in_ready=1.
  - Each accepted beat is written into its lane; beat index increments.
  - The 4th beat, or any beat with in_last, completes the word. Unfilled lanes are forced to 0. Next state is PUSH; the completion is latched as last_seen when in_last was set.
- PUSH:
  - in_ready=0.
  - wr_en = !wr_full (combinational); wr_data is held stable while wr_full=1.
  - On the write cycle, word count increments, beat index clears and the lane register clears to 0.
  - Exit after the write:
    - last_seen and count==WORDS -> FILL, sample_count++, count=0.
    - last_seen and count<WORDS -> PAD.
    - !last_seen and count==WORDS -> DROP, overflow=1.
    - otherwise -> FILL.
- PAD:
  - in_ready=0.
  - Emits all-zero words with wr_en = !wr_full until count==WORDS.
  - Then -> FILL, sample_count++, count=0.
- DROP:
  - in_ready=1.
  - Beats are accepted and discarded; wr_en=0.
  - A beat with in_last -> FILL, sample_count++, count=0.
- Throughput: 1 word per 5 cycles when wr_full=0 (4 FILL beats + 1 PUSH cycle).
- wr_en is never asserted while wr_full=1.
- No word is ever written with a partially stale lane.
- in_last on the exact final beat (beat 4 of word WORDS) takes no PAD or DROP and does not set overflow.
- Reset mid-record discards the partial word and the word count. sample_count and overflow clear.
- in_valid=0 in FILL stalls without changing state. Gaps between beats are allowed.

Optional Feature:
- SVM_PACK_BSWAP_EN defined: each accepted beat is byte-reversed before placement, for big-endian sources. in_data[31:24] becomes the earliest byte of that beat and lands in lane bits [32k+7:32k].
- Macro undefined: no swap, as described above.
- Framing, padding and the overflow flag are identical in both builds.

Test Plan:
- Exact record: 2048 beats with in_data = beat index, in_last on beat 2048, wr_full=0.
  - Expect 512 writes; word 0 = {32'd3,32'd2,32'd1,32'd0}; sample_count=1; overflow=0.
- Short record: 5 beats 0x11111111..0x55555555, in_last on beat 5.
  - Expect word 0 = {4{0x44444444..0x11111111 in order}}; word 1 = {96'b0,32'h55555555}; then 510 zero words; sample_count=1.
- Long record: 2050 beats, in_last on beat 2050.
  - Expect exactly 512 writes; overflow=1 after the 512th write; 2 beats dropped; sample_count=1.
- Backpressure: hold wr_full=1 for 20 cycles at the first PUSH.
  - Expect wr_en=0 and in_ready=0 throughout; wr_data stable; a single write when wr_full drops; no data loss.
- Async reset: assert reset_n=0 mid-word (beat 2) and mid-PAD.
  - Expect outputs reset immediately without a clock edge; the next record starts at lane 0 with count 0.
- Macro build: with SVM_PACK_BSWAP_EN, beat 0x04030201 as first beat.
  - Expect wr_data[31:0]=0x01020304.

Source files
------------

// File: rtl/svm_packer.sv
// svm_packer: packs 32-bit feature beats into 128-bit FIFO words and frames each record to SAMPLE_BYTES.
// Optional build macro SVM_PACK_BSWAP_EN byte-reverses every accepted beat for big-endian sources.
module svm_packer #(
    parameter int SAMPLE_BYTES = 8192
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [127:0] wr_data,
    output logic         wr_en,
    input  logic         wr_full,
    output logic [15:0]  sample_count,
    output logic         overflow,
    output logic [1:0]   dbg_state
);

    localparam int WORDS = SAMPLE_BYTES / 16;
    localparam int CW    = $clog2(WORDS + 1);

    // Handshake: a beat moves when in_valid && in_ready at a rising edge; a word is
    // taken by the FIFO on every rising edge where wr_en is high (wr_en implies !wr_full).
    typedef enum logic [1:0] {
        FILL = 2'd0,
        PUSH = 2'd1,
        PAD  = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     beat_q, beat_d;
    logic [CW-1:0]  count_q, count_d;
    logic [127:0]   lane_q, lane_d;
    logic           last_seen_q, last_seen_d;
    logic [15:0]    sample_count_q, sample_count_d;
    logic           overflow_q, overflow_d;

    logic [31:0]    beat_data;
    logic [CW-1:0]  count_inc;
    logic           at_end;

`ifdef SVM_PACK_BSWAP_EN
    assign beat_data = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
    assign beat_data = in_data;
`endif

    assign count_inc = count_q + CW'(1);
    assign at_end    = (count_inc == CW'(WORDS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= FILL;
            beat_q         <= 2'd0;
            count_q        <= '0;
            lane_q         <= '0;
            last_seen_q    <= 1'b0;
            sample_count_q <= 16'd0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            count_q        <= count_d;
            lane_q         <= lane_d;
            last_seen_q    <= last_seen_d;
            sample_count_q <= sample_count_d;
            overflow_q     <= overflow_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        count_d        = count_q;
        lane_d         = lane_q;
        last_seen_d    = last_seen_q;
        sample_count_d = sample_count_q;
        overflow_d     = overflow_q;
        case (state_q)
            FILL: begin
                // Lanes beyond a short final beat are already zero: the lane register clears on every write.
                if (in_valid) begin
                    lane_d[{beat_q, 5'd0} +: 32] = beat_data;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3 || in_last) begin
                        state_d     = PUSH;
                        last_seen_d = in_last;
                    end
                end
            end
            PUSH: begin
                if (!wr_full) begin
                    count_d = count_inc;
                    beat_d  = 2'd0;
                    lane_d  = '0;
                    if (last_seen_q && at_end) begin
                        state_d        = FILL;
                        sample_count_d = sample_count_q + 16'd1;
                        count_d        = '0;
                    end else if (last_seen_q) begin
                        state_d = PAD;
                    end else if (at_end) begin
                        state_d    = DROP;
                        overflow_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            PAD: begin
                if (!wr_full) begin
                    count_d = count_inc;
                    if (at_end) begin
                        state_d        = FILL;
                        sample_count_d = sample_count_q + 16'd1;
                        count_d        = '0;
                    end
                end
            end
            DROP: begin
                if (in_valid && in_last) begin
                    state_d        = FILL;
                    sample_count_d = sample_count_q + 16'd1;
                    count_d        = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready = (state_q == FILL) || (state_q == DROP);
        wr_en    = ((state_q == PUSH) || (state_q == PAD)) && !wr_full;
    end

    assign wr_data      = lane_q;
    assign sample_count = sample_count_q;
    assign overflow     = overflow_q;
    assign dbg_state    = state_q;

endmodule
